// File: rtl/pe_mac_pkg.sv
// Shared constants and lane-slicing helpers for the multi-filter PE MAC.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pe_mac_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_FILTER_WIDTH = 8;
    localparam int DEF_NUM_FILTERS  = 4;
    localparam int DEF_PSUM_WIDTH   = 24;
    localparam int DEF_PSUM_DEPTH   = 8;

    // Width of one raw lane product and of the FIFO occupancy count at defaults.
    localparam int PROD_W = DEF_DATA_WIDTH + DEF_FILTER_WIDTH;
    localparam int CNT_W  = $clog2(DEF_PSUM_DEPTH) + 1;

    // Lowest bit of lane 'lane' inside a bus of lanes each 'width' bits wide.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Highest bit of lane 'lane' inside a bus of lanes each 'width' bits wide.
    function automatic int lane_msb(input int lane, input int width);
        return lane * width + width - 1;
    endfunction

endpackage

// File: rtl/pe_multi_filter_mac_psum_fifo.sv
// First-word-fall-through FIFO holding packed psum vectors, with occupancy count.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: upstream credits keep it from filling; writes when full and pops when empty are dropped.
module psum_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_rd   = rd_en && (count_q != '0);
    assign do_wr   = wr_en && ((count_q != (PTR_W+1)'(DEPTH)) || do_rd);
    assign valid   = (count_q != '0);
    assign count   = count_q;
    // Head is forced to zero while empty so stale storage never leaks out.
    assign rd_data = valid ? mem[rd_ptr] : '0;

    // Storage array: no reset needed, the head is masked until written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pe_multi_filter_mac.sv
// Shared-IFMap multi-filter MAC: one multiply-accumulate per lane per beat, one psum vector per window.
// Latency: accept at edge t, product at t+1, accumulate/FIFO write at t+2 (psum_valid the cycle after).
// Backpressure: in_ready from registered credits (FIFO count + window closes still in flight).
module pe_multi_filter_mac
    import pe_mac_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FILTER_WIDTH = DEF_FILTER_WIDTH,
    parameter int NUM_FILTERS  = DEF_NUM_FILTERS,
    parameter int PSUM_WIDTH   = DEF_PSUM_WIDTH,
    parameter int PSUM_DEPTH   = DEF_PSUM_DEPTH,
    parameter int SATURATE     = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH-1:0]               ifmap_in,
    input  logic [NUM_FILTERS*FILTER_WIDTH-1:0] filter_in,
    input  logic                                in_last,
    output logic [NUM_FILTERS*PSUM_WIDTH-1:0]   psum_out,
    output logic                                psum_valid,
    input  logic                                psum_ren,
    output logic [$clog2(PSUM_DEPTH):0]         psum_count,
    output logic [NUM_FILTERS-1:0]              overflow,
    output logic                                busy
);

    localparam int PROD_WIDTH = DATA_WIDTH + FILTER_WIDTH;
    localparam int CNT_WIDTH  = $clog2(PSUM_DEPTH) + 1;
    localparam int BUS_WIDTH  = NUM_FILTERS * PSUM_WIDTH;

    // Stage 0: captured beat.
    logic                                s0_valid;
    logic                                s0_last;
    logic [DATA_WIDTH-1:0]               s0_ifmap;
    logic [NUM_FILTERS*FILTER_WIDTH-1:0] s0_filter;

    // Stage 1: products live in the lanes; only control is shared.
    logic                                s1_valid;
    logic                                s1_last;

    // Set while accumulators hold a partially summed window.
    logic                                open_win;

    logic                                accept;
    logic                                push;
    logic [1:0]                          inflight;
    logic [CNT_WIDTH:0]                  credit_use;
    logic [BUS_WIDTH-1:0]                push_data;

    assign accept = in_valid && in_ready;
    assign push   = s1_valid && s1_last;
    assign busy   = s0_valid || s1_valid || open_win;

    // Credit check: every window close already in the pipe owns a FIFO slot.
    always_comb begin
        inflight   = 2'(s0_valid && s0_last) + 2'(s1_valid && s1_last);
        credit_use = {1'b0, psum_count} + (CNT_WIDTH+1)'(inflight);
        in_ready   = credit_use < (CNT_WIDTH+1)'(PSUM_DEPTH);
    end

    // Stage 0 capture of the accepted beat; clear drops anything offered that cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s0_valid  <= 1'b0;
            s0_last   <= 1'b0;
            s0_ifmap  <= '0;
            s0_filter <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_last   <= in_last;
                s0_ifmap  <= ifmap_in;
                s0_filter <= filter_in;
            end
        end
    end

    // Stage 1 control follows stage 0 with no stalls; bubbles carry valid=0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            s1_last  <= s0_valid && s0_last;
        end
    end

    // Track whether a window has started but not yet closed.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            open_win <= 1'b0;
        end else if (s1_valid) begin
            open_win <= !s1_last;
        end
    end

    for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_lane
        logic [FILTER_WIDTH-1:0] weight;
        logic [PROD_WIDTH-1:0]   prod;
        logic [PSUM_WIDTH-1:0]   prod_q;
        logic [PSUM_WIDTH-1:0]   acc_q;
        logic [PSUM_WIDTH:0]     sum;
        logic [PSUM_WIDTH-1:0]   result;
        logic                    ovf_q;

        assign weight = s0_filter[lane_lsb(k, FILTER_WIDTH) +: FILTER_WIDTH];
        assign prod   = PROD_WIDTH'(s0_ifmap) * PROD_WIDTH'(weight);

        // Extra top bit of the sum is the carry-out that flags saturation or wrap.
        always_comb begin
            sum = {1'b0, acc_q} + {1'b0, prod_q};
            if (sum[PSUM_WIDTH] && (SATURATE != 0)) begin
                result = '1;
            end else begin
                result = sum[PSUM_WIDTH-1:0];
            end
        end

        // Stage 1 product register, zero-extended into the accumulator width.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                prod_q <= '0;
            end else if (s0_valid) begin
                prod_q <= PSUM_WIDTH'(prod);
            end
        end

        // Stage 2 accumulate; a closing beat hands the sum to the FIFO and restarts at zero.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (s1_valid) begin
                acc_q <= s1_last ? '0 : result;
                if (sum[PSUM_WIDTH]) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        assign push_data[k*PSUM_WIDTH +: PSUM_WIDTH] = result;
        assign overflow[k]                           = ovf_q;
    end

    psum_fifo #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (PSUM_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (psum_ren),
        .rd_data (psum_out),
        .valid   (psum_valid),
        .count   (psum_count)
    );

endmodule

// File: tb/tb_pe_multi_filter_mac.sv
// Directed bench for pe_multi_filter_mac: a saturating and a wrapping instance share one stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_pe_multi_filter_mac;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int NF = 4;
    localparam int PW = 24;
    localparam int PD = 8;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic           in_valid;
    logic           in_last;
    logic           psum_ren;
    logic [DW-1:0]  ifmap_in;
    logic [NF*FW-1:0] filter_in;

    logic           in_ready, psum_valid, busy;
    logic [NF*PW-1:0] psum_out;
    logic [CW-1:0]  psum_count;
    logic [NF-1:0]  overflow;

    logic           w_in_ready, w_psum_valid, w_busy;
    logic [NF*PW-1:0] w_psum_out;
    logic [CW-1:0]  w_psum_count;
    logic [NF-1:0]  w_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc;

    always #5 clk = ~clk;

    pe_multi_filter_mac #(
        .DATA_WIDTH(DW), .FILTER_WIDTH(FW), .NUM_FILTERS(NF),
        .PSUM_WIDTH(PW), .PSUM_DEPTH(PD), .SATURATE(1)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .ifmap_in(ifmap_in), .filter_in(filter_in), .in_last(in_last),
        .psum_out(psum_out), .psum_valid(psum_valid), .psum_ren(psum_ren),
        .psum_count(psum_count), .overflow(overflow), .busy(busy)
    );

    pe_multi_filter_mac #(
        .DATA_WIDTH(DW), .FILTER_WIDTH(FW), .NUM_FILTERS(NF),
        .PSUM_WIDTH(PW), .PSUM_DEPTH(PD), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
        .ifmap_in(ifmap_in), .filter_in(filter_in), .in_last(in_last),
        .psum_out(w_psum_out), .psum_valid(w_psum_valid), .psum_ren(psum_ren),
        .psum_count(w_psum_count), .overflow(w_overflow), .busy(w_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [NF*FW-1:0] f, input logic l);
        ifmap_in  = d;
        filter_in = f;
        in_last   = l;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic pop_one();
        psum_ren = 1'b1;
        step();
        psum_ren = 1'b0;
    endtask

    function automatic logic [NF*PW-1:0] lanes(input logic [PW-1:0] v);
        return {NF{v}};
    endfunction

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; psum_ren = 1'b0;
        ifmap_in = '0; filter_in = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_psum_valid", psum_valid, 0);
        check("rst_psum_count", psum_count, 0);
        check("rst_busy", busy, 0);
        check("rst_psum_out", psum_out, 0);
        check("rst_overflow", overflow, 0);

        // 3-beat window, weights {1,2,3,4}: psum = 6*w
        send(16'd1, 32'h04030201, 1'b0);
        send(16'd2, 32'h04030201, 1'b0);
        send(16'd3, 32'h04030201, 1'b1);
        check("w3_valid_t", psum_valid, 0);
        check("w3_busy_t", busy, 1);
        step();
        check("w3_valid_t1", psum_valid, 0);
        step();
        check("w3_valid_t2", psum_valid, 1);
        check("w3_count", psum_count, 1);
        check("w3_psum", psum_out, {24'd24, 24'd18, 24'd12, 24'd6});
        check("w3_busy_idle", busy, 0);
        pop_one();
        check("w3_pop_count", psum_count, 0);
        check("w3_pop_valid", psum_valid, 0);

        // Back-to-back 1-beat windows until credits run out
        filter_in = 32'h01010101;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        n_acc     = 0;
        for (int c = 0; c < 14; c++) begin
            ifmap_in = 16'(n_acc + 1);
            if (in_ready) n_acc++;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) step();
        check("fill_accepted", n_acc, 8);
        check("fill_count", psum_count, 8);
        check("fill_in_ready", in_ready, 0);
        check("fill_head", psum_out, lanes(24'd1));
        pop_one();
        check("fill_ready_back", in_ready, 1);
        check("fill_count7", psum_count, 7);
        for (int i = 2; i <= 8; i++) begin
            check("fill_order", psum_out, lanes(PW'(i)));
            pop_one();
        end
        check("fill_drained", psum_count, 0);

        // Pop while empty is ignored
        pop_one();
        check("empty_pop_count", psum_count, 0);
        check("empty_pop_valid", psum_valid, 0);
        check("empty_pop_out", psum_out, 0);
        check("empty_pop_ready", in_ready, 1);

        // Simultaneous push and pop at count 3
        send(16'd10, 32'h01010101, 1'b1);
        send(16'd20, 32'h01010101, 1'b1);
        send(16'd30, 32'h01010101, 1'b1);
        step();
        step();
        check("pp_count_before", psum_count, 3);
        check("pp_head_before", psum_out, lanes(24'd10));
        send(16'd40, 32'h01010101, 1'b1);
        step();
        pop_one();
        check("pp_count_after", psum_count, 3);
        check("pp_head_after", psum_out, lanes(24'd20));
        pop_one();
        check("pp_head_next", psum_out, lanes(24'd30));
        pop_one();
        check("pp_head_last", psum_out, lanes(24'd40));
        pop_one();
        check("pp_drained", psum_count, 0);

        // 300 beats of 0xFFFF * 0xFF: saturating vs wrapping lanes
        for (int i = 0; i < 300; i++) begin
            send(16'hFFFF, 32'hFFFFFFFF, (i == 299));
        end
        step();
        step();
        check("sat_count", psum_count, 1);
        check("sat_psum", psum_out, lanes(24'hFFFFFF));
        check("sat_overflow", overflow, 4'hF);
        check("wrap_psum", w_psum_out, lanes(24'hD2D52C));
        check("wrap_overflow", w_overflow, 4'hF);
        pop_one();
        check("sat_sticky", overflow, 4'hF);
        check("sat_drained", psum_count, 0);

        // Clear mid-window, then a clean 2-beat window
        send(16'd7, 32'h03030303, 1'b0);
        send(16'd7, 32'h03030303, 1'b0);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_overflow", overflow, 0);
        check("clr_wrap_overflow", w_overflow, 0);
        check("clr_in_ready", in_ready, 1);
        check("clr_valid", psum_valid, 0);
        send(16'd5, 32'h02020202, 1'b0);
        send(16'd5, 32'h02020202, 1'b1);
        step();
        step();
        check("clr_count", psum_count, 1);
        check("clr_psum", psum_out, lanes(24'd20));
        check("clr_wrap_psum", w_psum_out, lanes(24'd20));
        pop_one();

        // Reset mid-stream with a full FIFO and overflow set
        send(16'hFFFF, 32'hFFFFFFFF, 1'b0);
        send(16'hFFFF, 32'hFFFFFFFF, 1'b1);
        step();
        step();
        check("rs_overflow_set", overflow, 4'hF);
        filter_in = 32'h01010101;
        ifmap_in  = 16'd9;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        repeat (12) step();
        check("rs_full_count", psum_count, 8);
        check("rs_full_ready", in_ready, 0);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("rs_count", psum_count, 0);
        check("rs_valid", psum_valid, 0);
        check("rs_overflow", overflow, 0);
        check("rs_in_ready", in_ready, 1);
        check("rs_busy", busy, 0);
        check("rs_psum_out", psum_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
